sobel_stream: RTL and testbench

Streaming 3×3 Sobel engine, the parametrised successor to the fixed 4-bit frame-address Sobel block. Accepts a raster-order grayscale pixel stream and emits one clamped Gx/Gy pair per input pixel, with its linear output address. Zero padding applies at all four image borders. Sits between the luminance (Y) extractor and the edge-map frame RAM writer.

---
 rtl/sobel_stream_if.sv | 28 ++
 rtl/sobel_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_sobel_stream.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_if.sv
// sobel_stream_if: control, pixel-in and gradient-out bundle for sobel_stream.
//   master: drives sobel_en, pix_valid, pix_in; observes the result/status signals.
//   slave : the Sobel engine; drives out_valid, Gx, Gy, out_addr, mag, busy, sobel_done.
interface sobel_stream_if #(
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned ADDR_W = 10
);
    logic              sobel_en;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_in;
    logic              out_valid;
    logic [PIX_W-1:0]  Gx;
    logic [PIX_W-1:0]  Gy;
    logic [ADDR_W-1:0] out_addr;
    logic [PIX_W-1:0]  mag;
    logic              busy;
    logic              sobel_done;

    modport master (
        output sobel_en, pix_valid, pix_in,
        input  out_valid, Gx, Gy, out_addr, mag, busy, sobel_done
    );

    modport slave (
        input  sobel_en, pix_valid, pix_in,
        output out_valid, Gx, Gy, out_addr, mag, busy, sobel_done
    );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel engine with zero padding at every border.
// Takes a raster-order gray stream and emits one clamped Gx/Gy pair (plus
// linear address) per pixel, one cycle after the beat that completes its window.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   bus.slave  - sobel_en/pix_valid/pix_in in; out_valid/Gx/Gy/out_addr/mag/busy/sobel_done out
// Optional feature: define SOBEL_MAG_EN to compute mag = min(|Gx|+|Gy|, max);
// otherwise mag is tied to zero.
module sobel_stream #(
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    sobel_stream_if.slave  bus
);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned NBEAT = NPIX + IMG_W + 1;
    localparam int unsigned CNT_W = $clog2(NBEAT);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned GW    = PIX_W + 3;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  beat_cnt;
    logic [COL_W-1:0]  beat_col;
    logic [COL_W-1:0]  ctr_col;
    logic [ROW_W-1:0]  ctr_row;
    logic [ADDR_W-1:0] ctr_addr;

    logic              beat_c, clear_c, done_c, emit_c;
    logic [PIX_W-1:0]  beat_pix_c;

    logic [PIX_W-1:0]  lb0 [IMG_W];
    logic [PIX_W-1:0]  lb1 [IMG_W];
    logic [PIX_W-1:0]  win_l [3];
    logic [PIX_W-1:0]  win_m [3];
    logic [PIX_W-1:0]  col_c [3];

    logic signed [GW-1:0] gx_c, gy_c;

    logic              out_valid_q, busy_q, done_q;
    logic [PIX_W-1:0]  gx_q, gy_q;
    logic [ADDR_W-1:0] addr_q;

    // Zero-extend a tap into the signed gradient width, or force it to zero when padded.
    function automatic logic signed [GW-1:0] tap(input logic [PIX_W-1:0] v, input logic ok);
        return ok ? $signed(GW'(v)) : '0;
    endfunction

    // Saturate a signed gradient into [0, 2^PIX_W-1].
    function automatic logic [PIX_W-1:0] clamp(input logic signed [GW-1:0] v);
        if (v[GW-1])
            return '0;
        else if (|v[GW-2:PIX_W])
            return PIX_MAX;
        else
            return v[PIX_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.sobel_en) state_nxt = S_RUN;
            S_RUN:   if (bus.pix_valid && (beat_cnt == CNT_W'(NPIX - 1))) state_nxt = S_FLUSH;
            S_FLUSH: if (beat_cnt == CNT_W'(NBEAT - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: which beat (if any) enters the window this cycle
    always_comb begin
        beat_c     = 1'b0;
        beat_pix_c = '0;
        clear_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_IDLE:  clear_c = 1'b1;
            S_RUN: begin
                beat_c     = bus.pix_valid;
                beat_pix_c = bus.pix_in;
            end
            S_FLUSH: beat_c = 1'b1;
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    // The first IMG_W+1 beats only prime the window; later beats each finish one centre.
    assign emit_c = beat_c && (beat_cnt >= CNT_W'(IMG_W + 1));

    // New right-hand window column: two rows up, one row up, incoming beat.
    always_comb begin
        col_c[0] = lb1[beat_col];
        col_c[1] = lb0[beat_col];
        col_c[2] = beat_pix_c;
    end

    // Line buffers and window need no reset: stale entries are always masked by padding.
    always_ff @(posedge clk) begin
        if (beat_c) begin
            lb1[beat_col] <= lb0[beat_col];
            lb0[beat_col] <= beat_pix_c;
            for (int r = 0; r < 3; r++) begin
                win_l[r] <= win_m[r];
                win_m[r] <= col_c[r];
            end
        end
    end

    // Gradients with border masks; column masks also block wrap-around from adjacent lines.
    always_comb begin
        logic top_ok, bot_ok, lft_ok, rgt_ok;
        logic signed [GW-1:0] p_mm, p_m0, p_mp, p_0m, p_0p, p_pm, p_p0, p_pp;
        top_ok = (ctr_row != '0);
        bot_ok = (ctr_row != ROW_W'(IMG_H - 1));
        lft_ok = (ctr_col != '0);
        rgt_ok = (ctr_col != COL_W'(IMG_W - 1));
        p_mm = tap(win_l[0], top_ok && lft_ok);
        p_m0 = tap(win_m[0], top_ok);
        p_mp = tap(col_c[0], top_ok && rgt_ok);
        p_0m = tap(win_l[1], lft_ok);
        p_0p = tap(col_c[1], rgt_ok);
        p_pm = tap(win_l[2], bot_ok && lft_ok);
        p_p0 = tap(win_m[2], bot_ok);
        p_pp = tap(col_c[2], bot_ok && rgt_ok);
        gx_c = (p_mp + (p_0p <<< 1) + p_pp) - (p_mm + (p_0m <<< 1) + p_pm);
        gy_c = (p_pm + (p_p0 <<< 1) + p_pp) - (p_mm + (p_m0 <<< 1) + p_mp);
    end

    // Counters and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            beat_col    <= '0;
            ctr_col     <= '0;
            ctr_row     <= '0;
            ctr_addr    <= '0;
            out_valid_q <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= emit_c;
            done_q      <= done_c;
            busy_q      <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
            if (clear_c) begin
                beat_cnt <= '0;
                beat_col <= '0;
                ctr_col  <= '0;
                ctr_row  <= '0;
                ctr_addr <= '0;
            end else if (beat_c) begin
                beat_cnt <= beat_cnt + 1'b1;
                beat_col <= (beat_col == COL_W'(IMG_W - 1)) ? '0 : beat_col + 1'b1;
                if (emit_c) begin
                    gx_q     <= clamp(gx_c);
                    gy_q     <= clamp(gy_c);
                    addr_q   <= ctr_addr;
                    ctr_addr <= ctr_addr + 1'b1;
                    if (ctr_col == COL_W'(IMG_W - 1)) begin
                        ctr_col <= '0;
                        ctr_row <= ctr_row + 1'b1;
                    end else begin
                        ctr_col <= ctr_col + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SOBEL_MAG_EN
    localparam int unsigned MW = GW + 1;

    logic [GW-1:0]    abs_gx_c, abs_gy_c;
    logic [MW-1:0]    mag_sum_c;
    logic [PIX_W-1:0] mag_q;

    // L1 magnitude from the unclamped gradients, saturated to the pixel range.
    always_comb begin
        abs_gx_c  = gx_c[GW-1] ? -gx_c : gx_c;
        abs_gy_c  = gy_c[GW-1] ? -gy_c : gy_c;
        mag_sum_c = MW'(abs_gx_c) + MW'(abs_gy_c);
    end

    always_ff @(posedge clk) begin
        if (rst)
            mag_q <= '0;
        else if (emit_c)
            mag_q <= (|mag_sum_c[MW-1:PIX_W]) ? PIX_MAX : mag_sum_c[PIX_W-1:0];
    end

    assign bus.mag = mag_q;
`else
    assign bus.mag = '0;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.Gx         = gx_q;
    assign bus.Gy         = gy_q;
    assign bus.out_addr   = addr_q;
    assign bus.busy       = busy_q;
    assign bus.sobel_done = done_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed and randomized frames on a 4x3 image, checked
// against a padded-convolution reference model and spec timing rules.
module tb_sobel_stream;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PW = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_stream_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

    sobel_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] gx;
        logic [31:0] gy;
        logic [31:0] mag;
        int          cyc;
    } out_t;

    out_t outs[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_busy = 1'b0;
    int   img [N];
    int   beat_cyc [N + W + 1];
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output and done pulse with the cycle it was seen in.
    always @(negedge clk) begin
        out_t o;
        if (bus.out_valid === 1'b1) begin
            o.addr = 32'(bus.out_addr);
            o.gx   = 32'(bus.Gx);
            o.gy   = 32'(bus.Gy);
            o.mag  = 32'(bus.mag);
            o.cyc  = cyc;
            outs.push_back(o);
        end
        if (bus.sobel_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return img[r * W + c];
    endfunction

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > 15) return 15;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic run_frame(input bit gap_alt, input bit gap_rand, input bit poke, input string nm);
        int gx, gy, r, c, em;
        outs.delete();
        done_cnt = 0;
        bus.sobel_en = 1'b1;
        @(negedge clk);
        bus.sobel_en = 1'b0;
        chk({nm, "_busy_rise"}, 32'(bus.busy), 1);
        for (int i = 0; i < N; i++) begin
            if (gap_alt || (gap_rand && $urandom_range(0, 2) == 0)) begin
                bus.pix_valid = 1'b0;
                bus.pix_in    = PW'($urandom);
                @(negedge clk);
            end
            bus.pix_valid = 1'b1;
            bus.pix_in    = PW'(img[i]);
            beat_cyc[i]   = cyc;
            if (poke && i == 5) bus.sobel_en = 1'b1;
            @(negedge clk);
            bus.sobel_en = 1'b0;
        end
        bus.pix_valid = 1'b0;
        for (int j = 0; j <= W; j++) beat_cyc[N + j] = beat_cyc[N - 1] + 1 + j;
        if (poke) begin
            bus.sobel_en  = 1'b1;
            bus.pix_valid = 1'b1;
            bus.pix_in    = 4'hF;
            @(negedge clk);
            bus.sobel_en  = 1'b0;
            bus.pix_valid = 1'b0;
        end
        for (int t = 0; t < 200 && done_cnt == 0; t++) @(negedge clk);
        chk({nm, "_done_seen"}, 32'(done_cnt), 1);
        repeat (3) @(negedge clk);
        chk({nm, "_done_count"}, 32'(done_cnt), 1);
        chk({nm, "_out_count"}, 32'(outs.size()), N);
        chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(beat_cyc[N + W] + 2));
        chk({nm, "_busy_at_done"}, 32'(done_busy), 0);
        for (int k = 0; k < outs.size() && k < N; k++) begin
            r  = k / W;
            c  = k % W;
            gx = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1))
               - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
            gy = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1))
               - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
`ifdef SOBEL_MAG_EN
            em = sat(iabs(gx) + iabs(gy));
`else
            em = 0;
`endif
            chk($sformatf("%s_addr%0d", nm, k), outs[k].addr, 32'(k));
            chk($sformatf("%s_gx%0d", nm, k), outs[k].gx, 32'(sat(gx)));
            chk($sformatf("%s_gy%0d", nm, k), outs[k].gy, 32'(sat(gy)));
            chk($sformatf("%s_mag%0d", nm, k), outs[k].mag, 32'(em));
            chk($sformatf("%s_cyc%0d", nm, k), 32'(outs[k].cyc), 32'(beat_cyc[k + W + 1] + 1));
        end
    endtask

    task automatic load_uniform();
        for (int i = 0; i < N; i++) img[i] = 5;
    endtask

    task automatic uniform_points(input string nm);
        if (outs.size() == N) begin
            chk({nm, "_a0_gx"}, outs[0].gx, 15);
            chk({nm, "_a0_gy"}, outs[0].gy, 15);
            chk({nm, "_a5_gx"}, outs[5].gx, 0);
            chk({nm, "_a5_gy"}, outs[5].gy, 0);
            chk({nm, "_a11_gx"}, outs[11].gx, 0);
            chk({nm, "_a11_gy"}, outs[11].gy, 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.sobel_en  = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_gx", 32'(bus.Gx), 0);
        chk("rst_gy", 32'(bus.Gy), 0);
        chk("rst_mag", 32'(bus.mag), 0);
        chk("rst_addr", 32'(bus.out_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.sobel_done), 0);
        rst = 1'b0;
        @(negedge clk);

        // pix_valid while idle must be ignored
        bus.pix_valid = 1'b1;
        bus.pix_in    = 4'h9;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("idle_pix_valid", 32'(bus.out_valid), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        load_uniform();
        run_frame(1'b0, 1'b0, 1'b0, "uni");
        uniform_points("uni");

        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 15 : 0;
        run_frame(1'b0, 1'b0, 1'b0, "vedge");
        if (outs.size() == N) begin
            chk("vedge_a5_gx", outs[5].gx, 15);
            chk("vedge_a5_gy", outs[5].gy, 0);
`ifdef SOBEL_MAG_EN
            chk("vedge_a5_mag", outs[5].mag, 15);
`else
            chk("vedge_a5_mag", outs[5].mag, 0);
`endif
        end

        load_uniform();
        run_frame(1'b1, 1'b0, 1'b0, "gaps");
        uniform_points("gaps");

        run_frame(1'b0, 1'b0, 1'b1, "poke");
        uniform_points("poke");

        // Reset after six pixels, then a fresh uniform frame
        outs.delete();
        bus.sobel_en = 1'b1;
        @(negedge clk);
        bus.sobel_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = 4'h5;
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_gx", 32'(bus.Gx), 0);
        chk("mid_rst_gy", 32'(bus.Gy), 0);
        chk("mid_rst_mag", 32'(bus.mag), 0);
        chk("mid_rst_addr", 32'(bus.out_addr), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.sobel_done), 0);
        bus.pix_valid = 1'b1;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_valid", 32'(bus.out_valid), 0);
        chk("post_rst_idle_busy", 32'(bus.busy), 0);
        run_frame(1'b0, 1'b0, 1'b0, "rerun");
        uniform_points("rerun");

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 15));
            run_frame(1'b0, 1'b1, 1'b0, $sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
